sp_cp_remove: RTL
=================

Name: sp_cp_remove

Overview:
- Parametrised serial-to-parallel converter with cyclic-prefix removal for the OFDM receiver front end.
- Accepts one complex sample per handshake and discards the first NCP samples of each symbol.
- Collects the remaining NFFT samples into a ping-pong buffer and presents them as one parallel frame, with a valid/ready handshake, to the FFT core.
- Successor to the fixed 16+4 converter: adds configurable size, backpressure, double buffering and symbol resync.

Parameters:
- WIDTH, 16, bits per real/imag component (signed two's complement).
- NFFT, 16, FFT size / parallel output lanes; power of two, 4..64.
- NCP, 4, cyclic-prefix length in samples; 0..NFFT-1.
- CNT_W, derived localparam, bits needed to count 0..NFFT+NCP-1 (not overridable).

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, din sample present.
- in_ready, output, 1, block can accept a sample this cycle.
- sym_start, input, 1, qualified by in_valid & in_ready; marks the current sample as index 0 of a symbol.
- din_real, input, WIDTH, signed sample real part.
- din_imag, input, WIDTH, signed sample imag part.
- out_valid, output, 1, parallel frame valid.
- out_ready, input, 1, downstream accepts frame.
- dout_real, output, NFFT*WIDTH, lane k at bits [k*WIDTH +: WIDTH].
- dout_imag, output, NFFT*WIDTH, same packing as dout_real.
- resync_err, output, 1, one-cycle pulse when sym_start arrives mid-symbol.
- sym_idx, output, CNT_W, current in-symbol sample index, for debug.

Behaviour:
- Reset: in_ready=1, out_valid=0, resync_err=0, sym_idx=0, dout_real/dout_imag=0, both banks empty, write bank = bank 0.
- Accept: a sample is accepted when in_valid & in_ready.
- Counter: sym_idx increments per accepted sample and wraps from NFFT+NCP-1 to 0.
- CP discard: samples with index < NCP are accepted and dropped.
- Storage: sample index i (i >= NCP) is written to lane i-NCP of the write bank.
- Resync: accepted sample with sym_start=1 is forced to index 0, and the partial write bank is discarded.
- resync_err: pulses 1 cycle later only if sym_idx != 0 at that moment. sym_start at index 0 is silent.
- Frame completion: on accepting index NFFT+NCP-1, the write bank becomes full.
  - If the read bank is empty (out_valid=0, or out_valid & out_ready in that same cycle), banks swap in that cycle.
  - out_valid=1 on the next cycle. Latency: last sample accepted to out_valid = 1 cycle.
- Full-bank stall: if the read bank is still occupied, the full write bank waits and in_ready=0.
  - The swap occurs in the cycle out_ready is seen; in_ready returns to 1 the following cycle.
- in_ready is registered-free (combinational): in_ready = !(write_bank_full & read_bank_occupied).
- Output hold: dout and out_valid are stable while out_valid & !out_ready.
- Output release: out_valid drops after the handshake unless a full write bank swaps in the same cycle, in which case out_valid stays 1 and dout updates.
- Simultaneous events: last-sample accept and output handshake in the same cycle → swap, back-to-back frames, no bubble.
- Reset mid-operation: all partial and held frames are discarded; no out_valid until a full new symbol arrives.
- NCP=0: every sample is stored; behaves as a pure S/P converter.
- Arithmetic: none; data is passed bit-exact.

Optional Feature:
- Macro: SP_CP_BITREV_OUT_EN.
- Defined: output lane k carries the sample whose post-CP index is bitrev(k, log2 NFFT), feeding a DIT FFT directly.
  - Implemented by permuting write addresses; no extra latency.
- Undefined: natural order, lane k = post-CP sample k.

Decomposition:
- Package ofdm_rx_pkg:
  - sample typedef (WIDTH-bit signed real/imag struct).
  - default NFFT/NCP constants.
  - bitrev function used by SP_CP_BITREV_OUT_EN and the FFT.
- Sub-module sp_pingpong_bank: two NFFT-entry register banks with write-lane select, swap, and read mux. Counter/handshake control stays in sp_cp_remove.

Test Plan:
- NFFT=16, NCP=4, continuous in_valid, out_ready=1, din_real=idx 0..19 → out_valid 1 cycle after idx 19; lane k = k+4; no stalls across 3 symbols.
- Hold out_ready=0 for 40 cycles while streaming 20-sample symbols → first frame stays stable; in_ready drops after second symbol's last sample; no sample lost; frames emitted in order after out_ready=1.
- sym_start at sym_idx=9 → resync_err pulse, partial frame discarded, next out_valid after 20 further samples with lane0 = 5th sample after restart.
- Random in_valid gaps (50%) with out_ready toggling → output frames match the reference model bit-exact; in_ready never 1 while both banks are full.
- rst asserted mid-symbol with a held frame → next cycle out_valid=0, in_ready=1, sym_idx=0; next frame is built only from post-reset samples.
- SP_CP_BITREV_OUT_EN defined, NFFT=8, NCP=2, samples 0..9 → lanes = 2,6,4,8,3,7,5,9.

Source files
------------

// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receiver types, default sizes and the bit-reverse helper.
// Used by sp_cp_remove, sp_pingpong_bank and the FFT core.
package ofdm_rx_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NFFT  = 16;
   localparam int DEF_NCP   = 4;

   typedef struct packed {
      logic signed [DEF_WIDTH-1:0] re;
      logic signed [DEF_WIDTH-1:0] im;
   } sample_t;

   function automatic int unsigned bitrev(
      input int unsigned v,
      input int unsigned bits
   );
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < bits; i++) begin
         r |= ((v >> i) & 1) << (bits - 1 - i);
      end
      return r;
   endfunction

endpackage

// File: rtl/sp_pingpong_bank.sv
// Two NFFT-lane register banks: one written lane-by-lane, one read in parallel.
// Ports: clk/rst, we_i+wlane_i+wre_i/wim_i write, swap_i flips banks, rre_o/rim_o read bank.
module sp_pingpong_bank
   import ofdm_rx_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NFFT  = DEF_NFFT,
   localparam int LW    = $clog2(NFFT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [LW-1:0]         wlane_i,
   input  logic [WIDTH-1:0]      wre_i,
   input  logic [WIDTH-1:0]      wim_i,
   input  logic                  swap_i,
   output logic [NFFT*WIDTH-1:0] rre_o,
   output logic [NFFT*WIDTH-1:0] rim_o
);

   logic [WIDTH-1:0] re_q [2][NFFT];
   logic [WIDTH-1:0] im_q [2][NFFT];
   logic             wsel_q;
   logic             rsel;

   assign rsel = ~wsel_q;

   // A write and a swap in the same cycle land in the bank being handed
   // to the reader, so the final sample is part of the outgoing frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         wsel_q <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NFFT; k++) begin
               re_q[b][k] <= '0;
               im_q[b][k] <= '0;
            end
         end
      end else begin
         if (we_i) begin
            re_q[wsel_q][wlane_i] <= wre_i;
            im_q[wsel_q][wlane_i] <= wim_i;
         end
         if (swap_i) begin
            wsel_q <= ~wsel_q;
         end
      end
   end

   always_comb begin
      rre_o = '0;
      rim_o = '0;
      for (int k = 0; k < NFFT; k++) begin
         rre_o[k*WIDTH +: WIDTH] = re_q[rsel][k];
         rim_o[k*WIDTH +: WIDTH] = im_q[rsel][k];
      end
   end

endmodule

// File: rtl/sp_cp_remove.sv
// Serial-to-parallel converter with cyclic-prefix removal and ping-pong output.
// Ports: in_valid/in_ready/sym_start/din_* in, out_valid/out_ready/dout_* out,
// resync_err pulse, sym_idx debug. Option macro: SP_CP_BITREV_OUT_EN.
module sp_cp_remove
   import ofdm_rx_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NFFT  = DEF_NFFT,
   parameter  int NCP   = DEF_NCP,
   localparam int CNT_W = $clog2(NFFT + NCP)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    sym_start,
   input  logic signed [WIDTH-1:0] din_real,
   input  logic signed [WIDTH-1:0] din_imag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NFFT*WIDTH-1:0]   dout_real,
   output logic [NFFT*WIDTH-1:0]   dout_imag,
   output logic                    resync_err,
   output logic [CNT_W-1:0]        sym_idx
);

   localparam int LW = $clog2(NFFT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NFFT + NCP - 1);

   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] eidx;
   logic             wfull_q, wfull_d;
   logic             ov_q, ov_d;
   logic             err_q, err_d;
   logic             acc, last, store;
   logic             full_now, swap;
   logic [LW-1:0]    lane_nat, lane;

   assign in_ready = !(wfull_q && ov_q);
   assign acc      = in_valid && in_ready;

   // sym_start forces index 0; the stale partial bank is simply
   // overwritten lane by lane as the new symbol arrives.
   assign eidx = sym_start ? '0 : idx_q;
   assign last = acc && (eidx == LAST);

   generate
      if (NCP == 0) begin : g_nocp
         assign store    = acc;
         assign lane_nat = LW'(eidx);
      end else begin : g_cp
         assign store    = acc && (eidx >= CNT_W'(NCP));
         assign lane_nat = LW'(eidx - CNT_W'(NCP));
      end
   endgenerate

`ifdef SP_CP_BITREV_OUT_EN
   assign lane = LW'(bitrev(32'(lane_nat), LW));
`else
   assign lane = lane_nat;
`endif

   // Swap when a full write bank exists and the read side is free
   // (idle, or handing off its frame this very cycle).
   assign full_now = wfull_q || last;
   assign swap     = full_now && (!ov_q || out_ready);

   always_comb begin
      idx_d = idx_q;
      if (acc) begin
         idx_d = (eidx == LAST) ? '0 : eidx + CNT_W'(1);
      end
      wfull_d = full_now && !swap;
      ov_d    = swap || (ov_q && !out_ready);
      err_d   = acc && sym_start && (idx_q != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         wfull_q <= 1'b0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         wfull_q <= wfull_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
      end
   end

   assign out_valid  = ov_q;
   assign resync_err = err_q;
   assign sym_idx    = idx_q;

   sp_pingpong_bank #(
      .WIDTH (WIDTH),
      .NFFT  (NFFT)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (store),
      .wlane_i (lane),
      .wre_i   (din_real),
      .wim_i   (din_imag),
      .swap_i  (swap),
      .rre_o   (dout_real),
      .rim_o   (dout_imag)
   );

endmodule
